// File: rtl/rx_fsrc_remove_holes.sv
// rtl/rx_fsrc_remove_holes.sv - drops hole samples from a multi-channel beat and repacks survivors into dense beats
module rx_fsrc_remove_holes #(
    parameter int NP          = 16,
    parameter int NUM_SAMPLES = 8,
    parameter int NUM_CH      = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CH-1:0][NP*NUM_SAMPLES-1:0]     in_data,
    input  logic [NUM_SAMPLES-1:0]                    in_holes,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [NUM_CH-1:0][NP*NUM_SAMPLES-1:0]     out_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [$clog2(2*NUM_SAMPLES+1)-1:0]        fill_level
);

    localparam int N  = NUM_SAMPLES;
    localparam int CW = $clog2(2*N+1);

    typedef logic [NP-1:0] sample_t;

    sample_t       comp   [NUM_CH][N];
    sample_t       s1_data[NUM_CH][N];
    sample_t       acc    [NUM_CH][2*N];
    sample_t       acc_n  [NUM_CH][2*N];
    logic [CW-1:0] s1_cnt;
    logic [CW-1:0] cnt;
    logic          s1_valid;
    logic          emit;
    logic          append;
    logic          in_xfer;
    int            c_in;
    int            post;
    int            cnt_n;

    // Stage-1 compaction: each kept sample lands at the number of kept samples before it.
    always_comb begin
        c_in = 0;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int k = 0; k < N; k++)
                comp[ch][k] = '0;
        for (int j = 0; j < N; j++) begin
            if (!in_holes[j]) begin
                for (int k = 0; k < N; k++)
                    if (k == c_in)
                        for (int ch = 0; ch < NUM_CH; ch++)
                            comp[ch][k] = in_data[ch][j*NP +: NP];
                c_in = c_in + 1;
            end
        end
    end

    always_comb begin
        emit     = (int'(cnt) >= N) && (!out_valid || out_ready);
        post     = int'(cnt) - (emit ? N : 0);
        append   = s1_valid && (post + int'(s1_cnt) <= 2*N);
        cnt_n    = post + (append ? int'(s1_cnt) : 0);
        in_ready = !reset && (!s1_valid || append);
        in_xfer  = in_valid && in_ready;

        acc_n = acc;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (emit)
                for (int p = 0; p < N; p++)
                    acc_n[ch][p] = acc[ch][p+N];
            // Stage-1 samples append behind whatever survives the emit shift.
            for (int p = 0; p < 2*N; p++)
                for (int k = 0; k < N; k++)
                    if (append && k < int'(s1_cnt) && p == post + k)
                        acc_n[ch][p] = s1_data[ch][k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_xfer)
                s1_valid <= 1'b1;
            else if (append)
                s1_valid <= 1'b0;
            cnt <= CW'(cnt_n);
            if (emit)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            s1_data <= comp;
            s1_cnt  <= CW'(c_in);
        end
        acc <= acc_n;
        if (emit)
            for (int ch = 0; ch < NUM_CH; ch++)
                for (int k = 0; k < N; k++)
                    out_data[ch][k*NP +: NP] <= acc[ch][k];
    end

    assign fill_level = cnt;

endmodule

// File: tb/tb_rx_fsrc_remove_holes.sv
// tb/tb_rx_fsrc_remove_holes.sv - self-checking bench for rx_fsrc_remove_holes
module tb_rx_fsrc_remove_holes;

    localparam int NP = 16;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [0:0][63:0] a_in_data, a_out_data;
    logic [3:0]       a_in_holes, a_fill;
    logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready;

    logic [2:0][63:0] b_in_data, b_out_data;
    logic [3:0]       b_in_holes, b_fill;
    logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready;

    rx_fsrc_remove_holes #(.NP(NP), .NUM_SAMPLES(N), .NUM_CH(1)) dut_a (
        .clk(clk), .reset(reset),
        .in_data(a_in_data), .in_holes(a_in_holes), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .fill_level(a_fill)
    );

    rx_fsrc_remove_holes #(.NP(NP), .NUM_SAMPLES(N), .NUM_CH(3)) dut_b (
        .clk(clk), .reset(reset),
        .in_data(b_in_data), .in_holes(b_in_holes), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .fill_level(b_fill)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [63:0] mk_beat(input int i);
        logic [63:0] r;
        for (int k = 0; k < N; k++) r[k*16 +: 16] = 16'(i*16 + k);
        return r;
    endfunction

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [3:0]  h;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_ov;
        logic [63:0] exp_od;
        logic [3:0]  exp_fill;
    } vec_t;

    vec_t tbl[10];

    logic [15:0] q[3][$];
    int          acc_beats;

    task automatic b_step();
        logic [63:0] e;
        #1;
        if (b_out_valid && b_out_ready) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (q[ch].size() < N) begin
                    check($sformatf("rand ch%0d model level", ch), 64'(q[ch].size()), 64'(N));
                end else begin
                    for (int k = 0; k < N; k++) e[k*16 +: 16] = q[ch].pop_front();
                    check($sformatf("rand ch%0d out_data", ch), b_out_data[ch], e);
                end
            end
        end
        if (b_in_valid && b_in_ready) begin
            for (int j = 0; j < N; j++)
                if (!b_in_holes[j])
                    for (int ch = 0; ch < 3; ch++) q[ch].push_back(b_in_data[ch][j*16 +: 16]);
            acc_beats++;
        end
    endtask

    initial begin
        int nxt, oidx;

        tbl[0] = '{1'b1, 64'h0003_0002_0001_0000, 4'b0000, 1'b1, 1'b1, 1'b0, 64'h0, 4'd0};
        tbl[1] = '{1'b0, 64'h0,                   4'b0000, 1'b1, 1'b1, 1'b0, 64'h0, 4'd4};
        tbl[2] = '{1'b0, 64'h0,                   4'b0000, 1'b1, 1'b1, 1'b1, 64'h0003_0002_0001_0000, 4'd0};
        tbl[3] = '{1'b1, 64'h00A3_00A2_00A1_00A0, 4'b0101, 1'b1, 1'b1, 1'b0, 64'h0, 4'd0};
        tbl[4] = '{1'b1, 64'h00B3_00B2_00B1_00B0, 4'b0000, 1'b1, 1'b1, 1'b0, 64'h0, 4'd2};
        tbl[5] = '{1'b0, 64'h0,                   4'b0000, 1'b1, 1'b1, 1'b0, 64'h0, 4'd6};
        tbl[6] = '{1'b0, 64'h0,                   4'b0000, 1'b1, 1'b1, 1'b1, 64'h00B1_00B0_00A3_00A1, 4'd2};
        tbl[7] = '{1'b0, 64'h0,                   4'b0000, 1'b1, 1'b1, 1'b0, 64'h0, 4'd2};
        tbl[8] = '{1'b1, 64'h00C3_00C2_00C1_00C0, 4'b1110, 1'b1, 1'b1, 1'b0, 64'h0, 4'd2};
        tbl[9] = '{1'b0, 64'h0,                   4'b0000, 1'b1, 1'b1, 1'b0, 64'h0, 4'd3};

        reset = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_holes = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_holes = '0; b_out_ready = 1'b1;

        @(negedge clk); #1;
        check("reset in_ready", 64'(a_in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(a_out_valid), 64'd0);
        check("reset fill_level", 64'(a_fill), 64'd0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_in_valid = tbl[i].v; a_in_data[0] = tbl[i].d;
            a_in_holes = tbl[i].h; a_out_ready = tbl[i].ordy;
            #1 check($sformatf("tbl%0d in_ready", i), 64'(a_in_ready), 64'(tbl[i].exp_rdy));
            @(posedge clk); #1;
            check($sformatf("tbl%0d out_valid", i), 64'(a_out_valid), 64'(tbl[i].exp_ov));
            check($sformatf("tbl%0d fill_level", i), 64'(a_fill), 64'(tbl[i].exp_fill));
            if (tbl[i].exp_ov)
                check($sformatf("tbl%0d out_data", i), a_out_data[0], tbl[i].exp_od);
        end

        // Reset with three samples held: they must not leak into the next beat.
        @(negedge clk);
        reset = 1'b1; a_in_valid = 1'b0;
        #1 check("midreset in_ready", 64'(a_in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midreset fill_level", 64'(a_fill), 64'd0);
        check("midreset out_valid", 64'(a_out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        a_in_valid = 1'b1; a_in_data[0] = 64'h00D3_00D2_00D1_00D0; a_in_holes = 4'b0000;
        #1 check("postreset in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk) a_in_valid = 1'b0;
        @(posedge clk); #1;
        check("postreset early out_valid", 64'(a_out_valid), 64'd0);
        @(posedge clk); #1;
        check("postreset out_valid", 64'(a_out_valid), 64'd1);
        check("postreset out_data", a_out_data[0], 64'h00D3_00D2_00D1_00D0);
        @(negedge clk);
        @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_holes = 4'b1111; a_in_data[0] = {$urandom, $urandom};
            #1 check($sformatf("holes%0d in_ready", i), 64'(a_in_ready), 64'd1);
            @(posedge clk); #1;
            check($sformatf("holes%0d out_valid", i), 64'(a_out_valid), 64'd0);
        end
        @(negedge clk) a_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("holes fill_level", 64'(a_fill), 64'd0);
        check("holes out_valid", 64'(a_out_valid), 64'd0);

        nxt = 0;
        oidx = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_holes = 4'b0000; a_in_data[0] = mk_beat(nxt); a_out_ready = 1'b0;
            #1 if (a_in_ready) nxt++;
        end
        @(posedge clk); #1;
        check("bp out_valid", 64'(a_out_valid), 64'd1);
        check("bp fill_level", 64'(a_fill), 64'd8);
        @(negedge clk);
        a_in_data[0] = mk_beat(nxt);
        #1 check("bp in_ready", 64'(a_in_ready), 64'd0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            a_out_ready = 1'b1;
            a_in_valid  = (nxt < 12);
            a_in_data[0] = mk_beat(nxt);
            #1;
            if (a_out_valid) begin
                check($sformatf("bp beat%0d", oidx), a_out_data[0], mk_beat(oidx));
                oidx++;
            end
            if (a_in_valid && a_in_ready) nxt++;
        end
        check("bp beats out", 64'(oidx), 64'd12);
        check("bp final fill", 64'(a_fill), 64'd0);

        acc_beats = 0;
        for (int cyc = 0; cyc < 60000 && acc_beats < 10000; cyc++) begin
            @(negedge clk);
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_in_holes  = 4'($urandom_range(0, 15));
            for (int ch = 0; ch < 3; ch++) b_in_data[ch] = {$urandom, $urandom};
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_step();
        end
        check("rand beats accepted", 64'(acc_beats), 64'd10000);
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            b_in_valid = 1'b0; b_out_ready = 1'b1;
            b_step();
        end
        @(posedge clk); #1;
        check("rand residual fill", 64'(b_fill), 64'(q[0].size()));
        check("rand residual below N", 64'(q[0].size() < N), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
